// File: rtl/tdm_pkg.sv
// Shared slot encoding and sizing for the TDM receive path.
// The slot codes match the select encoding of the transmit-side multiplexer.
package tdm_pkg;

  typedef enum logic [1:0] {
    SL_A    = 2'd0,
    SL_B    = 2'd1,
    SL_C    = 2'd2,
    SL_IDLE = 2'd3
  } slot_e;

  localparam int NUM_SLOTS = 3;
  localparam int HOLD_MAX  = 15;
  localparam int CNT_W     = 4;

  function automatic slot_e next_slot(input slot_e s);
    case (s)
      SL_A:    return SL_B;
      SL_B:    return SL_C;
      default: return SL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tdm_slot_timer.sv
// Hold counter for one TDM slot: counts 0..HOLD-1 while running.
// 'clear' forces the current cycle to count 0, so a sync cycle is already the first slot cycle.
module tdm_slot_timer
  import tdm_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_eff;

  assign cnt_eff = clear ? '0 : cnt_q;
  assign last    = (cnt_eff == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!run || last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_eff + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demultiplexer.sv
// Receive side of the 3-channel TDM link: recovers a/b/c from the shared line and
// publishes each complete frame atomically with a one-cycle strobe.
module tdm_demultiplexer
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [1:0]       slot
);

  slot_e state_q, state_d;
  slot_e cur_slot;
  logic  run, last, sample, publish, abort;

  logic [WIDTH-1:0] sh_a, sh_b;

  // A sync restarts slot 0 in the same cycle, whatever state we were in.
  assign cur_slot = sync ? SL_A : state_q;
  assign run      = (cur_slot != SL_IDLE);

  tdm_slot_timer #(.HOLD(HOLD)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (sync),
    .run   (run),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    publish = 1'b0;
    abort   = sync && (state_q != SL_IDLE);
    if (run) begin
      sample  = last;
      state_d = last ? next_slot(cur_slot) : cur_slot;
      publish = last && (cur_slot == SL_C);
    end
  end

  // NOTE: shadows are reset along with the outputs; no stale data can leak into a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a        <= '0;
      sh_b        <= '0;
      out_a       <= '0;
      out_b       <= '0;
      out_c       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= publish;
      frame_err   <= abort;
      if (sample && cur_slot == SL_A) sh_a <= din;
      if (sample && cur_slot == SL_B) sh_b <= din;
      // Channel c is taken straight from the line so the frame lands in one edge.
      if (publish) begin
        out_a <= sh_a;
        out_b <= sh_b;
        out_c <= din;
      end
    end
  end

  assign slot = state_q;

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Bench for tdm_demultiplexer: three instances (HOLD 1, 2, 10) with a shared
// frame/error scoreboard, a per-cycle vector table and hand-written abort/reset sequences.
module tb_tdm_demultiplexer;

  typedef struct {
    int         inst;
    logic [11:0] data;
    int         cyc;
  } frame_t;

  typedef struct {
    int inst;
    int cyc;
  } err_t;

  typedef struct {
    logic        sync;
    logic [3:0]  din;
    logic [2:0]  slot;   // 4 = don't care
    logic        valid;
    logic        err;
    logic [11:0] out;    // {c,b,a}
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] din_h1, out_h1_a, out_h1_b, out_h1_c;
  logic       sync_h1, fv_h1, fe_h1;
  logic [1:0] slot_h1;
  logic [3:0] din_h2, out_h2_a, out_h2_b, out_h2_c;
  logic       sync_h2, fv_h2, fe_h2;
  logic [1:0] slot_h2;
  logic [0:0] din_h10, out_h10_a, out_h10_b, out_h10_c;
  logic       sync_h10, fv_h10, fe_h10;
  logic [1:0] slot_h10;

  tdm_demultiplexer #(.WIDTH(4), .HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .din(din_h1), .sync(sync_h1),
    .out_a(out_h1_a), .out_b(out_h1_b), .out_c(out_h1_c),
    .frame_valid(fv_h1), .frame_err(fe_h1), .slot(slot_h1));

  tdm_demultiplexer #(.WIDTH(4), .HOLD(2)) u_h2 (
    .clk(clk), .rst_n(rst_n), .din(din_h2), .sync(sync_h2),
    .out_a(out_h2_a), .out_b(out_h2_b), .out_c(out_h2_c),
    .frame_valid(fv_h2), .frame_err(fe_h2), .slot(slot_h2));

  tdm_demultiplexer #(.WIDTH(1), .HOLD(10)) u_h10 (
    .clk(clk), .rst_n(rst_n), .din(din_h10), .sync(sync_h10),
    .out_a(out_h10_a), .out_b(out_h10_b), .out_c(out_h10_c),
    .frame_valid(fv_h10), .frame_err(fe_h10), .slot(slot_h10));

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  frame_t exp_q[$];
  err_t   err_q[$];
  vec_t   tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops the scoreboard whenever any instance strobes.
  task automatic monitor();
    logic        fv, fe;
    logic [11:0] dat;
    frame_t      ef;
    err_t        ee;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin fv = fv_h1; fe = fe_h1; dat = {out_h1_c, out_h1_b, out_h1_a}; end
        1: begin fv = fv_h2; fe = fe_h2; dat = {out_h2_c, out_h2_b, out_h2_a}; end
        default: begin
          fv = fv_h10; fe = fe_h10;
          dat = {3'b000, out_h10_c, 3'b000, out_h10_b, 3'b000, out_h10_a};
        end
      endcase
      if (fv && fe) check($sformatf("dut%0d valid_and_err", k), 32'(fv & fe), 32'd0);
      if (fv) begin
        if (exp_q.size() == 0) begin
          check($sformatf("dut%0d spurious_valid", k), 32'(fv), 32'd0);
        end else begin
          ef = exp_q.pop_front();
          check($sformatf("dut%0d valid_inst", k), 32'(k), 32'(ef.inst));
          check($sformatf("dut%0d frame_data", k), 32'(dat), 32'(ef.data));
          check($sformatf("dut%0d valid_cycle", k), 32'(cyc), 32'(ef.cyc));
        end
      end
      if (fe) begin
        if (err_q.size() == 0) begin
          check($sformatf("dut%0d spurious_err", k), 32'(fe), 32'd0);
        end else begin
          ee = err_q.pop_front();
          check($sformatf("dut%0d err_inst", k), 32'(k), 32'(ee.inst));
          check($sformatf("dut%0d err_cycle", k), 32'(cyc), 32'(ee.cyc));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_h1"},  32'({out_h1_c, out_h1_b, out_h1_a, fv_h1, fe_h1, slot_h1}), 32'h3);
    check({tag, "_h2"},  32'({out_h2_c, out_h2_b, out_h2_a, fv_h2, fe_h2, slot_h2}), 32'h3);
    check({tag, "_h10"}, 32'({out_h10_c, out_h10_b, out_h10_a, fv_h10, fe_h10, slot_h10}), 32'h3);
  endtask

  // One full HOLD=10 frame; only the sample cycle carries real data.
  task automatic send_h10(input logic a, input logic b, input logic c);
    int t = cyc;
    exp_q.push_back('{2, {3'b000, c, 3'b000, b, 3'b000, a}, t + 30});
    for (int i = 0; i < 30; i++) begin
      sync_h10 = (i == 0);
      if (i % 10 == 9) din_h10 = (i < 10) ? a : (i < 20) ? b : c;
      else             din_h10 = 1'($urandom);
      if (i % 10 == 5) check("h10_slot", 32'(slot_h10), 32'(i / 10));
      tick();
    end
    sync_h10 = 1'b0;
  endtask

  initial begin
    int t;
    rst_n    = 1'b0;
    sync_h1  = 1'b0; din_h1  = '0;
    sync_h2  = 1'b0; din_h2  = '0;
    sync_h10 = 1'b0; din_h10 = '0;

    tbl = '{
      '{1'b0, 4'h0, 3'd3, 1'b0, 1'b0, 12'h000},
      '{1'b0, 4'h0, 3'd3, 1'b0, 1'b0, 12'h000},
      '{1'b0, 4'h0, 3'd3, 1'b0, 1'b0, 12'h000},
      '{1'b0, 4'h0, 3'd3, 1'b0, 1'b0, 12'h000},
      '{1'b0, 4'h6, 3'd3, 1'b0, 1'b0, 12'h000},
      '{1'b1, 4'h1, 3'd4, 1'b0, 1'b0, 12'h000},
      '{1'b0, 4'h0, 3'd1, 1'b0, 1'b0, 12'h000},
      '{1'b0, 4'h1, 3'd2, 1'b0, 1'b0, 12'h000},
      '{1'b1, 4'h3, 3'd4, 1'b1, 1'b0, 12'h101},
      '{1'b0, 4'h5, 3'd1, 1'b0, 1'b0, 12'h101},
      '{1'b0, 4'h9, 3'd2, 1'b0, 1'b0, 12'h101},
      '{1'b1, 4'hA, 3'd4, 1'b1, 1'b0, 12'h953},
      '{1'b0, 4'hB, 3'd1, 1'b0, 1'b0, 12'h953},
      '{1'b0, 4'hC, 3'd2, 1'b0, 1'b0, 12'h953},
      '{1'b0, 4'h0, 3'd3, 1'b1, 1'b0, 12'hCBA},
      '{1'b0, 4'hF, 3'd3, 1'b0, 1'b0, 12'hCBA},
      '{1'b0, 4'h7, 3'd3, 1'b0, 1'b0, 12'hCBA}
    };

    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    cyc   = 0;

    // HOLD=1: first frame after reset, then back-to-back frames.
    exp_q.push_back('{0, 12'h101, 8});
    exp_q.push_back('{0, 12'h953, 11});
    exp_q.push_back('{0, 12'hCBA, 14});
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].slot != 3'd4) check("h1_slot", 32'(slot_h1), 32'(tbl[i].slot));
      check("h1_valid", 32'(fv_h1), 32'(tbl[i].valid));
      check("h1_err", 32'(fe_h1), 32'(tbl[i].err));
      check("h1_out", 32'({out_h1_c, out_h1_b, out_h1_a}), 32'(tbl[i].out));
      sync_h1 = tbl[i].sync;
      din_h1  = tbl[i].din;
      tick();
    end
    sync_h1 = 1'b0;

    // HOLD=10 stream of one-hot frames.
    send_h10(1'b1, 1'b0, 1'b0);
    send_h10(1'b0, 1'b1, 1'b0);
    send_h10(1'b0, 1'b0, 1'b1);
    repeat (3) tick();

    // HOLD=2: good frame, abort in SLOT_B, abort in last cycle of SLOT_C, then completion.
    t = cyc;
    exp_q.push_back('{1, 12'h321, t + 6});
    err_q.push_back('{1, t + 10});
    err_q.push_back('{1, t + 15});
    exp_q.push_back('{1, 12'h987, t + 20});
    for (int i = 0; i < 21; i++) begin
      sync_h2 = (i == 0 || i == 6 || i == 9 || i == 14);
      case (i)
        1:       din_h2 = 4'h1;
        3:       din_h2 = 4'h2;
        5:       din_h2 = 4'h3;
        7:       din_h2 = 4'h4;
        10:      din_h2 = 4'h5;
        12:      din_h2 = 4'h6;
        15:      din_h2 = 4'h7;
        17:      din_h2 = 4'h8;
        19:      din_h2 = 4'h9;
        default: din_h2 = 4'($urandom);
      endcase
      if (i == 14 || i == 15 || i == 19)
        check("h2_out_held", 32'({out_h2_c, out_h2_b, out_h2_a}), 32'h321);
      if (i == 15) check("h2_slot_restart", 32'(slot_h2), 32'd0);
      tick();
    end
    sync_h2 = 1'b0;
    repeat (2) tick();

    // Reset in the middle of SLOT_C of a HOLD=10 frame.
    for (int i = 0; i < 25; i++) begin
      sync_h10 = (i == 0);
      din_h10  = 1'b1;
      tick();
    end
    sync_h10 = 1'b0;
    check("h10_slot_pre_rst", 32'(slot_h10), 32'd2);
    check("h10_out_pre_rst", 32'({out_h10_c, out_h10_b, out_h10_a}), 32'h4);
    rst_n = 1'b0;
    #1;
    check_idle_zero("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din_h1  = 4'($urandom);
      din_h2  = 4'($urandom);
      din_h10 = 1'($urandom);
      tick();
    end
    check_idle_zero("post_rst");

    check("frames_left", 32'(exp_q.size()), 32'd0);
    check("errs_left", 32'(err_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
